// File: rtl/xbus_pkg.sv
// Shared defaults and types for the row multicast bus.
// The broadcast default and id_t follow the default 4-bit ID width.
package xbus_pkg;

    localparam int XBUS_ID_LEN = 4;

    typedef logic [XBUS_ID_LEN-1:0] id_t;

    localparam id_t XBUS_BCAST_ID = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/xbus_id_chain.sv
// PE ID scan chain: words enter at the top index and leave from index 0.
// The IDs are exported flattened, one ID_LEN slice per PE.
module xbus_id_chain #(
    parameter int PE_NUMS = 14,
    parameter int ID_LEN  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set_id,
    input  logic [ID_LEN-1:0]           id_scan_in,
    output logic [ID_LEN-1:0]           id_scan_out,
    output logic [PE_NUMS*ID_LEN-1:0]   id_flat
);

    logic [ID_LEN-1:0] r_id [PE_NUMS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PE_NUMS; i++) begin
                r_id[i] <= '0;
            end
        end else if (set_id) begin
            for (int i = 0; i < PE_NUMS-1; i++) begin
                r_id[i] <= r_id[i+1];
            end
            r_id[PE_NUMS-1] <= id_scan_in;
        end
    end

    always_comb begin
        id_flat = '0;
        for (int i = 0; i < PE_NUMS; i++) begin
            id_flat[i*ID_LEN +: ID_LEN] = r_id[i];
        end
    end

    assign id_scan_out = r_id[0];

endmodule

// File: rtl/mcast_xbus.sv
// Row multicast bus: one tagged word is held until every matching PE takes it.
// Words that match no PE are dropped and counted (saturating).
module mcast_xbus
    import xbus_pkg::*;
#(
    parameter int                PE_NUMS  = 14,
    parameter int                ID_LEN   = XBUS_ID_LEN,
    parameter int                DATA_W   = 8,
    parameter logic [ID_LEN-1:0] BCAST_ID = '1,
    parameter int                CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ID_LEN-1:0]   in_tag,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                set_id,
    input  logic [ID_LEN-1:0]   id_scan_in,
    output logic [ID_LEN-1:0]   id_scan_out,
    output logic [PE_NUMS-1:0]  pe_valid,
    input  logic [PE_NUMS-1:0]  pe_ready,
    output logic [DATA_W-1:0]   pe_data,
    output logic [CNT_W-1:0]    drop_cnt
);

    logic [PE_NUMS*ID_LEN-1:0]  w_id_flat;
    logic [PE_NUMS-1:0]         w_match;
    logic [PE_NUMS-1:0]         w_pending_nxt;
    logic                       w_accept;
    logic                       w_hit;
    logic                       w_drain_done;
    state_e                     w_state_nxt;

    logic [PE_NUMS-1:0]         r_pending;
    logic [DATA_W-1:0]          r_data;
    logic [CNT_W-1:0]           r_drop_cnt;
    state_e                     r_state;

    xbus_id_chain #(
        .PE_NUMS (PE_NUMS),
        .ID_LEN  (ID_LEN)
    ) u_id_chain (
        .clk         (clk),
        .rst         (rst),
        .set_id      (set_id),
        .id_scan_in  (id_scan_in),
        .id_scan_out (id_scan_out),
        .id_flat     (w_id_flat)
    );

    always_comb begin
        w_match = '0;
        for (int i = 0; i < PE_NUMS; i++) begin
            w_match[i] = (w_id_flat[i*ID_LEN +: ID_LEN] == in_tag) || (in_tag == BCAST_ID);
        end
    end

    assign w_drain_done = ((r_pending & ~pe_ready) == '0);

    // Output process: a new word may enter in the same cycle the last target drains.
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            IDLE:    in_ready = !set_id;
            BUSY:    in_ready = !set_id && w_drain_done;
            default: in_ready = 1'b0;
        endcase
        in_ready = in_ready && rst;
    end

    assign pe_valid = r_pending;
    assign pe_data  = r_data;
    assign drop_cnt = r_drop_cnt;

    // Next-state process: a matching accept replaces pending, otherwise drain.
    always_comb begin
        w_accept      = in_valid && in_ready;
        w_hit         = w_accept && (w_match != '0);
        w_pending_nxt = w_hit ? w_match : (r_pending & ~pe_ready);
        w_state_nxt   = (w_pending_nxt != '0) ? BUSY : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_data     <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_hit) begin
                r_data <= in_data;
            end
            if (w_accept && !w_hit && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

endmodule
